// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALUOp codes, control-field layout and bubble constants for the pipelined MIPS control.
package ctrl_pkg;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] FN_MUL  = 6'b011000;

    localparam logic [1:0] ALU_MEM = 2'b00;
    localparam logic [1:0] ALU_BEQ = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;

    // mem = {MemRead, MemWrite}, wb = {RegWrite, MemtoReg}
    localparam int MEM_RD = 1;
    localparam int MEM_WR = 0;
    localparam int WB_RW  = 1;
    localparam int WB_M2R = 0;

    typedef logic [1:0] mem_ctrl_t;
    typedef logic [1:0] wb_ctrl_t;

    localparam mem_ctrl_t MEM_BUBBLE = 2'b00;
    localparam wb_ctrl_t  WB_BUBBLE  = 2'b00;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational Op/Funct decode into EX/MEM/WB control fields plus branch/jump/illegal/mul flags.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W = 2
) (
    input  logic [5:0]         op_i,
    input  logic [5:0]         funct_i,
    output logic [ALUOP_W+1:0] ex_o,
    output mem_ctrl_t          mem_o,
    output wb_ctrl_t           wb_o,
    output logic               branch_o,
    output logic               jump_o,
    output logic               illegal_o,
    output logic               is_mul_o
);
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;

    always_comb begin
        reg_dst   = 1'b0;
        alu_src   = 1'b0;
        alu_op    = ALU_MEM;
        mem_o     = MEM_BUBBLE;
        wb_o      = WB_BUBBLE;
        branch_o  = 1'b0;
        jump_o    = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            OP_R: begin
                reg_dst      = 1'b1;
                alu_op       = ALU_R;
                wb_o[WB_RW]  = 1'b1;
            end
            OP_ADDI: begin
                alu_src      = 1'b1;
                wb_o[WB_RW]  = 1'b1;
            end
            OP_LW: begin
                alu_src       = 1'b1;
                mem_o[MEM_RD] = 1'b1;
                wb_o[WB_RW]   = 1'b1;
                wb_o[WB_M2R]  = 1'b1;
            end
            OP_SW: begin
                alu_src       = 1'b1;
                mem_o[MEM_WR] = 1'b1;
            end
            OP_BEQ: begin
                branch_o = 1'b1;
                alu_op   = ALU_BEQ;
            end
            OP_J:    jump_o    = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

    assign ex_o     = {reg_dst, alu_src, ALUOP_W'(alu_op)};
    assign is_mul_o = (op_i == OP_R) && (funct_i == FN_MUL);
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined main control carrying EX/MEM/WB fields through ID/EX, EX/MEM and MEM/WB,
// with hazard/flush bubbles, multi-cycle MUL self-stall and a saturating illegal-opcode counter.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W   = 2,
    parameter int MUL_LAT   = 4,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [5:0]           Op_i,
    input  logic [5:0]           Funct_i,
    input  logic                 hazard_i,
    input  logic                 flush_i,
    output logic                 branch_o,
    output logic                 jump_o,
    output logic                 busy_o,
    output logic [ALUOP_W+1:0]   ex_ctrl_o,
    output logic [1:0]           mem_ctrl_o,
    output logic [1:0]           wb_ctrl_o,
    output logic                 illegal_o,
    output logic [ILL_CNT_W-1:0] illegal_cnt_o
);
    localparam int EX_W  = ALUOP_W + 2;
    localparam int CNT_W = $clog2(MUL_LAT + 1);
    // MUL_LAT=1 loads zero here, so a single-cycle MUL never raises busy
    localparam logic [CNT_W-1:0] MUL_HOLD = CNT_W'(MUL_LAT - 1);

    logic [EX_W-1:0]      dec_ex, idex_ex_d, idex_ex_q;
    mem_ctrl_t            dec_mem, idex_mem_d, idex_mem_q, exmem_mem_d, exmem_mem_q;
    wb_ctrl_t             dec_wb, idex_wb_d, idex_wb_q, exmem_wb_d, exmem_wb_q, memwb_wb_d, memwb_wb_q;
    logic                 dec_ill, dec_mul, busy, issue;
    logic [CNT_W-1:0]     cnt_d, cnt_q;
    logic [ILL_CNT_W-1:0] ill_d, ill_q;

    ctrl_decode #(.ALUOP_W(ALUOP_W)) u_dec (
        .op_i      (Op_i),
        .funct_i   (Funct_i),
        .ex_o      (dec_ex),
        .mem_o     (dec_mem),
        .wb_o      (dec_wb),
        .branch_o  (branch_o),
        .jump_o    (jump_o),
        .illegal_o (dec_ill),
        .is_mul_o  (dec_mul)
    );

    always_comb begin
        busy        = cnt_q != '0;
        issue       = valid_i & ~busy & ~hazard_i & ~flush_i;
        idex_ex_d   = busy ? idex_ex_q  : issue ? dec_ex  : '0;
        idex_mem_d  = busy ? idex_mem_q : issue ? dec_mem : MEM_BUBBLE;
        idex_wb_d   = busy ? idex_wb_q  : issue ? dec_wb  : WB_BUBBLE;
        exmem_mem_d = busy ? MEM_BUBBLE : idex_mem_q;
        exmem_wb_d  = busy ? WB_BUBBLE  : idex_wb_q;
        memwb_wb_d  = exmem_wb_q;
        cnt_d       = busy ? cnt_q - 1'b1 : (issue & dec_mul) ? MUL_HOLD : '0;
        ill_d       = (valid_i & dec_ill & ~busy & ~hazard_i & ~&ill_q) ? ill_q + 1'b1 : ill_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_ex_q   <= '0;
            idex_mem_q  <= MEM_BUBBLE;
            idex_wb_q   <= WB_BUBBLE;
            exmem_mem_q <= MEM_BUBBLE;
            exmem_wb_q  <= WB_BUBBLE;
            memwb_wb_q  <= WB_BUBBLE;
            cnt_q       <= '0;
            ill_q       <= '0;
        end else begin
            idex_ex_q   <= idex_ex_d;
            idex_mem_q  <= idex_mem_d;
            idex_wb_q   <= idex_wb_d;
            exmem_mem_q <= exmem_mem_d;
            exmem_wb_q  <= exmem_wb_d;
            memwb_wb_q  <= memwb_wb_d;
            cnt_q       <= cnt_d;
            ill_q       <= ill_d;
        end
    end

    assign busy_o        = busy;
    assign ex_ctrl_o     = idex_ex_q;
    assign mem_ctrl_o    = exmem_mem_q;
    assign wb_ctrl_o     = memwb_wb_q;
    assign illegal_o     = valid_i & dec_ill;
    assign illegal_cnt_o = ill_q;
endmodule
